// File: rtl/seq_controller.sv
// seq_controller: FETCH/DECODE/EXEC instruction sequencer with PC, IR, carry flag and retire counter.
// Optional SEQ_SINGLE_STEP_EN adds a step input and a WAIT state between instructions.
module seq_controller (
  input  logic       clk,
  input  logic       R,
  input  logic       run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] instr,
  input  logic       carry_in,
  output logic [3:0] pc,
  output logic [2:0] imm,
  output logic       mux_sel,
  output logic       alu_sub,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_o,
  output logic       halted,
  output logic       busy,
  output logic [7:0] retired
);
`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT, WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
`endif
  state_t state, state_nxt;
  logic [7:0] ir, ir_nxt;
  logic       cf, cf_nxt;
  logic [3:0] pc_nxt;
  logic [7:0] retired_nxt;
  logic [1:0] flow;
  logic       jump;
  assign flow    = ir[7:6];
  assign imm     = ir[2:0];
  assign mux_sel = ir[3];
  assign alu_sub = ir[2];
  assign halted  = state == HALT;
  assign busy    = state == FETCH || state == DECODE || state == EXEC;
  // JNC tests the flag as it stood before this EXEC's own carry capture
  assign jump    = flow == 2'b10 || (flow == 2'b01 && !cf);
`ifdef SEQ_SINGLE_STEP_EN
  logic step_q, step_rise;
  always_ff @(posedge clk or posedge R)
    if (R) step_q <= 1'b0;
    else step_q <= step;
  assign step_rise = step & ~step_q;
`endif
  always_comb begin
    state_nxt   = state;
    ir_nxt      = ir;
    cf_nxt      = cf;
    pc_nxt      = pc;
    retired_nxt = retired;
    ld_a        = 1'b0;
    ld_b        = 1'b0;
    ld_o        = 1'b0;
    case (state)
      IDLE:   state_nxt = run ? FETCH : IDLE;
      FETCH:  begin
        ir_nxt    = instr;
        state_nxt = DECODE;
      end
      DECODE: state_nxt = EXEC;
      EXEC:   begin
        ld_a        = flow != 2'b11 && ir[5:4] == 2'b00;
        ld_b        = flow != 2'b11 && ir[5:4] == 2'b01;
        ld_o        = flow != 2'b11 && ir[5:4] == 2'b10;
        cf_nxt      = ir[3] ? cf : carry_in;
        retired_nxt = retired + 8'd1;
        pc_nxt      = flow == 2'b11 ? pc : jump ? {1'b0, ir[2:0]} : pc + 4'd1;
`ifdef SEQ_SINGLE_STEP_EN
        state_nxt   = flow == 2'b11 ? HALT : WAIT;
`else
        state_nxt   = flow == 2'b11 ? HALT : run ? FETCH : IDLE;
`endif
      end
`ifdef SEQ_SINGLE_STEP_EN
      WAIT:   state_nxt = !run ? IDLE : step_rise ? FETCH : WAIT;
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge R)
    if (R) begin
      state   <= IDLE;
      ir      <= 8'd0;
      cf      <= 1'b0;
      pc      <= 4'd0;
      retired <= 8'd0;
    end else begin
      state   <= state_nxt;
      ir      <= ir_nxt;
      cf      <= cf_nxt;
      pc      <= pc_nxt;
      retired <= retired_nxt;
    end
endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: random programs run against an instruction-level reference model; a monitor
// pops the expected architectural state each time the retire counter moves.
module tb_seq_controller;
  logic       clk = 1'b0, R = 1'b0, run = 1'b0, carry_in;
  logic [7:0] instr, retired;
  logic [3:0] pc;
  logic [2:0] imm;
  logic       mux_sel, alu_sub, ld_a, ld_b, ld_o, halted, busy;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step = 1'b0;
`endif
  logic [7:0] rom [16];
  logic       cin_rom [16];
  always #5 clk = ~clk;
  assign instr    = rom[pc];
  assign carry_in = cin_rom[pc];
  seq_controller dut (
    .clk(clk), .R(R), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .instr(instr), .carry_in(carry_in), .pc(pc), .imm(imm), .mux_sel(mux_sel),
    .alu_sub(alu_sub), .ld_a(ld_a), .ld_b(ld_b), .ld_o(ld_o), .halted(halted),
    .busy(busy), .retired(retired)
  );
  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] ret;
    logic       halted;
    logic [2:0] ld;
    logic [2:0] imm;
    logic       mux;
    logic       sub;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int mpc, mret;
  bit mcf, mhalt;
  // one instruction of the program, from the field definitions
  task automatic model_step();
    logic [7:0] ir;
    int fl, dst;
    bit cin;
    exp_t e;
    ir  = rom[mpc];
    cin = cin_rom[mpc];
    fl  = int'(ir[7:6]);
    dst = int'(ir[5:4]);
    e.ld  = (fl == 3 || dst == 3) ? 3'b000 : 3'b100 >> dst;
    e.imm = ir[2:0];
    e.mux = ir[3];
    e.sub = ir[2];
    if (fl == 0) mpc = (mpc + 1) % 16;
    else if (fl == 1) mpc = mcf ? (mpc + 1) % 16 : int'(ir[2:0]);
    else if (fl == 2) mpc = int'(ir[2:0]);
    else mhalt = 1;
    if (!ir[3]) mcf = cin;
    mret = (mret + 1) % 256;
    e.pc = 4'(mpc);
    e.ret = 8'(mret);
    e.halted = mhalt;
    sb.push_back(e);
  endtask
  logic [7:0] last_ret = 8'd0;
  logic [2:0] prev_ld = 3'b000;
  logic [4:0] prev_f = 5'd0;
  exp_t e_mon, got;
  always @(negedge clk) begin
    if (R) begin
      last_ret = retired;
      prev_ld = 3'b000;
    end else begin
      if (ld_a | ld_b | ld_o) begin
        checks++;
        if ($countones({ld_a, ld_b, ld_o}) != 1 || prev_ld != 3'b000) begin
          errors++;
          $display("FAIL ld_pulse got ld=%b previous=%b, required a single one-cycle one-hot pulse",
                   {ld_a, ld_b, ld_o}, prev_ld);
        end
      end
      if (retired != last_ret && sb.size() > 0) begin
        e_mon = sb.pop_front();
        got = {pc, retired, halted, prev_ld, prev_f};
        checks++;
        if (got !== e_mon) begin
          errors++;
          $display("FAIL retire got pc=%0d ret=%0d halted=%b ld=%b imm=%0d mux=%b sub=%b, required pc=%0d ret=%0d halted=%b ld=%b imm=%0d mux=%b sub=%b",
                   got.pc, got.ret, got.halted, got.ld, got.imm, got.mux, got.sub,
                   e_mon.pc, e_mon.ret, e_mon.halted, e_mon.ld, e_mon.imm, e_mon.mux, e_mon.sub);
        end
        checks++;
`ifdef SEQ_SINGLE_STEP_EN
        if (busy !== 1'b0) begin
`else
        if (busy !== (run && !e_mon.halted)) begin
`endif
          errors++;
          $display("FAIL busy_after_exec got %b run=%b halted_expected=%b", busy, run, e_mon.halted);
        end
      end
      last_ret = retired;
      prev_ld = {ld_a, ld_b, ld_o};
    end
    prev_f = {imm, mux_sel, alu_sub};
  end
  task automatic do_reset();
    @(negedge clk);
    #1 R = 1'b1;
    run = 1'b0;
    #1 checks++;
    if ({pc, busy, halted, retired, ld_a, ld_b, ld_o} !== '0) begin
      errors++;
      $display("FAIL reset got pc=%0d busy=%b halted=%b retired=%0d ld=%b, required all zero",
               pc, busy, halted, retired, {ld_a, ld_b, ld_o});
    end
    sb.delete();
    mpc = 0; mcf = 0; mret = 0; mhalt = 0;
    @(negedge clk);
    #1 R = 1'b0;
  endtask
  task automatic run_episode(input int n, input int mode);
    int t;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'($urandom);
      cin_rom[i] = 1'($urandom);
      if (mode == 1 || (rom[i][7:6] == 2'b11 && $urandom_range(0, 2) != 0)) rom[i][7:6] = 2'b00;
    end
    if (mode == 2) begin
      rom[0] = 8'h0D; rom[1] = 8'h73; rom[2] = 8'hF0;
      rom[3] = 8'h20; rom[4] = 8'h73; rom[5] = 8'hB2;
      for (int i = 0; i < 16; i++) cin_rom[i] = (i == 3);
    end
    for (int k = 0; k < n && !mhalt; k++) model_step();
    t = 0;
    while (sb.size() > 0 && t < n * 16 + 100) begin
      @(negedge clk);
      #1 run = $urandom_range(0, 3) != 0;
`ifdef SEQ_SINGLE_STEP_EN
      step = 1'($urandom);
`endif
      t++;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL timeout got %0d retirements outstanding, required 0", sb.size());
    end
    if (mhalt) begin
      repeat (5) @(negedge clk);
      checks++;
      if (!(halted && !busy && pc == 4'(mpc))) begin
        errors++;
        $display("FAIL halt_hold got halted=%b busy=%b pc=%0d, required halted=1 busy=0 pc=%0d",
                 halted, busy, pc, mpc);
      end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got no completion, required finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'h00;
      cin_rom[i] = 1'b0;
    end
    run_episode(6, 2);
    for (int j = 0; j < 8; j++) run_episode(40, 0);
    run_episode(260, 1);
`ifdef SEQ_SINGLE_STEP_EN
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 8'h30;
    step = 1'b0;
    run = 1'b1;
    for (int t = 0; t < 20 && retired != 8'd1; t++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (retired !== 8'd1) begin
      errors++;
      $display("FAIL step_wait got retired=%0d, required 1", retired);
    end
    #1 step = 1'b1;
    repeat (5) @(negedge clk);
    #1 step = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (retired !== 8'd2) begin
      errors++;
      $display("FAIL step_once got retired=%0d, required 2", retired);
    end
`endif
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
